// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter
//  Description : Arbitrates the single read and single write port of the PIO
//                instruction regfile between up to NUM_FSM fetching state
//                machines (round-robin) and the SPI program loader. At most
//                one access (one write or one fetch) is granted per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_arbiter #(
    parameter int NUM_FSM = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    // FSM fetch side
    input  logic [NUM_FSM-1:0]        fetch_req,
    input  logic [NUM_FSM*ADDR_W-1:0] fetch_addr,
    output logic [NUM_FSM-1:0]        fetch_valid,
    output logic [DATA_W-1:0]         fetch_data,
    // loader write side
    input  logic                      wr_req,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ack,
    // regfile side
    output logic [ADDR_W-1:0]         rf_read_addr,
    input  logic [DATA_W-1:0]         rf_data_out,
    output logic [ADDR_W-1:0]         rf_write_addr,
    output logic                      rf_write_en,
    output logic [DATA_W-1:0]         rf_data_in
);

    // Width of the round-robin pointer; at least one bit even for tiny configs.
    localparam int c_PTR_W = (NUM_FSM > 1) ? $clog2(NUM_FSM) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NUM_FSM - 1);

    // Kind of access granted in the current cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_READ  = 2'd1,
        SLOT_WRITE = 2'd2
    } slot_e;

    // Registered state
    logic [NUM_FSM-1:0] r_fetch_valid_q;
    logic [DATA_W-1:0]  r_fetch_data_q;
    logic               r_wr_ack_q;
    logic [c_PTR_W-1:0] r_rr_ptr_q;
    logic               r_last_was_wr_q;

    // Next-state values
    logic [NUM_FSM-1:0] w_fetch_valid_d;
    logic [DATA_W-1:0]  w_fetch_data_d;
    logic               w_wr_ack_d;
    logic [c_PTR_W-1:0] w_rr_ptr_d;
    logic               w_last_was_wr_d;

    // Arbitration wires
    logic [NUM_FSM-1:0] w_eff_rd;
    logic               w_eff_wr;
    logic               w_any_rd;
    logic               w_rd_found;
    logic [c_PTR_W-1:0] w_cand_idx;
    logic [c_PTR_W-1:0] w_grant_idx;
    logic [NUM_FSM-1:0] w_grant_onehot;
    logic [c_PTR_W-1:0] w_grant_next;
    slot_e              w_slot;

    // Per-FSM program counters split out of the packed bus
    logic [ADDR_W-1:0]  w_fetch_addr_arr [NUM_FSM];

    for (genvar gi = 0; gi < NUM_FSM; gi++) begin : g_addr_unpack
        assign w_fetch_addr_arr[gi] = fetch_addr[gi*ADDR_W +: ADDR_W];
    end

    // A requester whose response is on the bus this cycle is not eligible;
    // otherwise a held request would be served twice for one handshake.
    always_comb begin
        w_eff_rd = fetch_req & ~r_fetch_valid_q;
        w_eff_wr = wr_req & ~r_wr_ack_q;
        w_any_rd = |w_eff_rd;
    end

    // Round-robin search: first eligible requester at or after the pointer.
    always_comb begin
        w_rd_found  = 1'b0;
        w_grant_idx = '0;
        w_cand_idx  = '0;
        for (int k = 0; k < NUM_FSM; k++) begin
            w_cand_idx = c_PTR_W'((int'(r_rr_ptr_q) + k) % NUM_FSM);
            if (!w_rd_found && w_eff_rd[w_cand_idx]) begin
                w_rd_found  = 1'b1;
                w_grant_idx = w_cand_idx;
            end
        end
    end

    // Winner decode: one-hot response flag and the pointer position after it.
    always_comb begin
        w_grant_onehot = NUM_FSM'(1) << w_grant_idx;
        if (w_grant_idx == c_PTR_LAST) begin
            w_grant_next = '0;
        end else begin
            w_grant_next = w_grant_idx + c_PTR_W'(1);
        end
    end

    // Slot decision: writes win, but never twice running while a fetch waits.
    always_comb begin
        w_slot = SLOT_IDLE;
        if (!rst) begin
            if (w_eff_wr && !(r_last_was_wr_q && w_any_rd)) begin
                w_slot = SLOT_WRITE;
            end else if (w_any_rd) begin
                w_slot = SLOT_READ;
            end
        end
    end

    // Regfile port drive; everything parks at zero when not granted.
    always_comb begin
        rf_read_addr  = '0;
        rf_write_addr = '0;
        rf_write_en   = 1'b0;
        rf_data_in    = '0;
        case (w_slot)
            SLOT_WRITE: begin
                rf_write_en   = 1'b1;
                rf_write_addr = wr_addr;
                rf_data_in    = wr_data;
            end
            SLOT_READ: begin
                rf_read_addr = w_fetch_addr_arr[w_grant_idx];
            end
            default: begin
            end
        endcase
    end

    // Next-state: response pulses last one cycle, fetch_data holds otherwise.
    always_comb begin
        w_fetch_valid_d = '0;
        w_fetch_data_d  = r_fetch_data_q;
        w_wr_ack_d      = 1'b0;
        w_rr_ptr_d      = r_rr_ptr_q;
        w_last_was_wr_d = 1'b0;
        case (w_slot)
            SLOT_WRITE: begin
                w_wr_ack_d      = 1'b1;
                w_last_was_wr_d = 1'b1;
            end
            SLOT_READ: begin
                w_fetch_valid_d = w_grant_onehot;
                w_fetch_data_d  = rf_data_out;
                w_rr_ptr_d      = w_grant_next;
            end
            default: begin
            end
        endcase
    end

    // State register; reset drops any response still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_valid_q <= '0;
            r_fetch_data_q  <= '0;
            r_wr_ack_q      <= 1'b0;
            r_rr_ptr_q      <= '0;
            r_last_was_wr_q <= 1'b0;
        end else begin
            r_fetch_valid_q <= w_fetch_valid_d;
            r_fetch_data_q  <= w_fetch_data_d;
            r_wr_ack_q      <= w_wr_ack_d;
            r_rr_ptr_q      <= w_rr_ptr_d;
            r_last_was_wr_q <= w_last_was_wr_d;
        end
    end

    assign fetch_valid = r_fetch_valid_q;
    assign fetch_data  = r_fetch_data_q;
    assign wr_ack      = r_wr_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_arbiter
//  Description : Self-checking bench for imem_arbiter with a behavioural
//                regfile, a cycle model of the arbitration rules and directed
//                scenarios with literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_arbiter;

    localparam int NUM_FSM = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_FSM-1:0]        fetch_req;
    logic [NUM_FSM*ADDR_W-1:0] fetch_addr;
    logic [NUM_FSM-1:0]        fetch_valid;
    logic [DATA_W-1:0]         fetch_data;
    logic                      wr_req;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      wr_ack;
    logic [ADDR_W-1:0]         rf_read_addr;
    logic [DATA_W-1:0]         rf_data_out;
    logic [ADDR_W-1:0]         rf_write_addr;
    logic                      rf_write_en;
    logic [DATA_W-1:0]         rf_data_in;

    logic [ADDR_W-1:0]         pc [NUM_FSM];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_arbiter #(
        .NUM_FSM (NUM_FSM),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_valid   (fetch_valid),
        .fetch_data    (fetch_data),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .rf_read_addr  (rf_read_addr),
        .rf_data_out   (rf_data_out),
        .rf_write_addr (rf_write_addr),
        .rf_write_en   (rf_write_en),
        .rf_data_in    (rf_data_in)
    );

    // Pack the per-FSM program counters onto the bus
    always_comb begin
        fetch_addr = '0;
        for (int i = 0; i < NUM_FSM; i++) begin
            fetch_addr[i*ADDR_W +: ADDR_W] = pc[i];
        end
    end

    // Instruction regfile: write at the edge, combinational read
    logic [DATA_W-1:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_write_addr] <= rf_data_in;
    end
    assign rf_data_out = rf_mem[rf_read_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who holds the response, what the memory holds,
    // whose turn it is. Checked against the DUT at every falling edge.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] m_mem [32] = '{default: 16'h0000};
    int                m_who     = -1;
    logic [DATA_W-1:0] m_data    = '0;
    bit                m_ack     = 1'b0;
    int                m_ptr     = 0;
    bit                m_last_wr = 1'b0;
    bit                m_ok      = 1'b0;

    initial begin : compare_proc
        int          winner;
        int          cand;
        int          kind;     // 0 idle, 1 fetch, 2 write
        bit          wr_pend;
        logic [31:0] e_we, e_wa, e_wd, e_ra;
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("model_fetch_valid", 32'(fetch_valid), (m_who < 0) ? 32'd0 : (32'd1 << m_who));
                chk("model_fetch_data", 32'(fetch_data), 32'(m_data));
                chk("model_wr_ack", 32'(wr_ack), 32'(m_ack));
            end
            winner = -1;
            for (int k = 0; k < NUM_FSM; k++) begin
                cand = (m_ptr + k) % NUM_FSM;
                if (winner < 0 && fetch_req[cand[1:0]] && m_who != cand) winner = cand;
            end
            wr_pend = wr_req && !m_ack;
            if (rst)                                    kind = 0;
            else if (wr_pend && !(m_last_wr && winner >= 0)) kind = 2;
            else if (winner >= 0)                       kind = 1;
            else                                        kind = 0;
            e_we = (kind == 2) ? 32'd1 : 32'd0;
            e_wa = (kind == 2) ? 32'(wr_addr) : 32'd0;
            e_wd = (kind == 2) ? 32'(wr_data) : 32'd0;
            e_ra = (kind == 1) ? 32'(pc[winner]) : 32'd0;
            if (m_ok || rst) begin
                chk("model_rf_write_en", 32'(rf_write_en), e_we);
                chk("model_rf_write_addr", 32'(rf_write_addr), e_wa);
                chk("model_rf_data_in", 32'(rf_data_in), e_wd);
                chk("model_rf_read_addr", 32'(rf_read_addr), e_ra);
            end
            if (rst) begin
                m_who = -1; m_data = '0; m_ack = 1'b0; m_ptr = 0; m_last_wr = 1'b0; m_ok = 1'b1;
            end else if (kind == 2) begin
                m_mem[wr_addr] = wr_data;
                m_ack = 1'b1; m_who = -1; m_last_wr = 1'b1;
            end else if (kind == 1) begin
                m_data = m_mem[pc[winner]];
                m_who = winner; m_ptr = (winner + 1) % NUM_FSM;
                m_ack = 1'b0; m_last_wr = 1'b0;
            end else begin
                m_who = -1; m_ack = 1'b0; m_last_wr = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_mid();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (wr_ack) begin
                wr_req = 1'b0;
                return;
            end
        end
        chk("write_ack_timeout", 32'd0, 32'd1);
        wr_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_req = '0; wr_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] t4_we [5] = '{1, 0, 1, 0, 1};
    logic [31:0] t4_ra [5] = '{0, 1, 0, 2, 0};
    logic [31:0] t4_fv [5] = '{0, 0, 2, 0, 4};
    logic [31:0] t4_ak [5] = '{0, 1, 0, 1, 0};

    initial begin : stim_proc
        rst = 1'b1; fetch_req = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < NUM_FSM; i++) pc[i] = '0;
        tick();
        tick();
        at_mid();
        chk("reset_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("reset_fetch_data", 32'(fetch_data), 32'd0);
        chk("reset_wr_ack", 32'(wr_ack), 32'd0);
        chk("reset_rf_write_en", 32'(rf_write_en), 32'd0);
        tick();
        rst = 1'b0;

        // T1: loader write addr 3 = A5C3
        wr_req = 1'b1; wr_addr = 5'd3; wr_data = 16'hA5C3;
        at_mid();
        chk("t1_write_en", 32'(rf_write_en), 32'd1);
        chk("t1_write_addr", 32'(rf_write_addr), 32'd3);
        chk("t1_write_data", 32'(rf_data_in), 32'hA5C3);
        chk("t1_ack_not_yet", 32'(wr_ack), 32'd0);
        tick();
        wr_req = 1'b0;
        at_mid();
        chk("t1_ack", 32'(wr_ack), 32'd1);
        chk("t1_no_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("t1_no_second_write", 32'(rf_write_en), 32'd0);
        tick();
        at_mid();
        chk("t1_ack_one_cycle", 32'(wr_ack), 32'd0);
        tick();

        // T2: FSM0 alone fetches addr 3
        pc[0] = 5'd3; fetch_req = 4'b0001;
        at_mid();
        chk("t2_read_addr", 32'(rf_read_addr), 32'd3);
        tick();
        at_mid();
        chk("t2_fetch_valid", 32'(fetch_valid), 32'h1);
        chk("t2_fetch_data", 32'(fetch_data), 32'hA5C3);
        chk("t2_masked_in_resp", 32'(rf_read_addr), 32'd0);
        tick();
        at_mid();
        chk("t2_regrant_n2", 32'(rf_read_addr), 32'd3);
        tick();
        fetch_req = '0;
        tick();

        // Preload 0x1000+addr at addresses 0..3 through the loader
        for (int a = 0; a < 4; a++) do_write(5'(a), 16'h1000 + 16'(a));
        do_reset();

        // T3: all four FSMs continuously
        for (int i = 0; i < NUM_FSM; i++) pc[i] = 5'(i);
        fetch_req = 4'hF;
        tick();
        for (int k = 0; k < 8; k++) begin
            at_mid();
            chk("t3_rotate_valid", 32'(fetch_valid), 32'd1 << (k % 4));
            chk("t3_rotate_data", 32'(fetch_data), 32'h1000 + 32'(k % 4));
            tick();
        end
        fetch_req = '0;
        tick();
        tick();
        do_reset();

        // T4: held write versus FSM1/FSM2 fetches
        pc[1] = 5'd1; pc[2] = 5'd2; fetch_req = 4'b0110;
        wr_req = 1'b1; wr_addr = 5'd8; wr_data = 16'h0808;
        for (int c = 0; c < 5; c++) begin
            at_mid();
            chk("t4_write_en", 32'(rf_write_en), t4_we[c]);
            chk("t4_read_addr", 32'(rf_read_addr), t4_ra[c]);
            chk("t4_fetch_valid", 32'(fetch_valid), t4_fv[c]);
            chk("t4_wr_ack", 32'(wr_ack), t4_ak[c]);
            tick();
            if (fetch_valid[1]) fetch_req[1] = 1'b0;
            if (fetch_valid[2]) fetch_req[2] = 1'b0;
        end
        wr_req = 1'b0;
        tick();
        tick();
        do_reset();

        // T5: read-after-write of addr 7
        pc[3] = 5'd7; fetch_req = 4'b1000;
        wr_req = 1'b1; wr_addr = 5'd7; wr_data = 16'hBEEF;
        at_mid();
        chk("t5_write_en", 32'(rf_write_en), 32'd1);
        chk("t5_write_addr", 32'(rf_write_addr), 32'd7);
        tick();
        wr_req = 1'b0;
        at_mid();
        chk("t5_read_addr", 32'(rf_read_addr), 32'd7);
        chk("t5_wr_ack", 32'(wr_ack), 32'd1);
        tick();
        fetch_req = '0;
        at_mid();
        chk("t5_fetch_valid", 32'(fetch_valid), 32'h8);
        chk("t5_fetch_data", 32'(fetch_data), 32'hBEEF);
        tick();
        do_reset();

        // T6: reset in the cycle after a fetch grant
        pc[1] = 5'd1; fetch_req = 4'b0010;
        at_mid();
        chk("t6_grant_fsm1", 32'(rf_read_addr), 32'd1);
        tick();
        rst = 1'b1; fetch_req = '0;
        at_mid();
        chk("t6_pulse_before_rst", 32'(fetch_valid), 32'h2);
        chk("t6_no_grant_in_rst", 32'(rf_read_addr), 32'd0);
        tick();
        rst = 1'b0;
        pc[1] = 5'd1; pc[2] = 5'd2; pc[3] = 5'd3; fetch_req = 4'b1110;
        at_mid();
        chk("t6_valid_cleared", 32'(fetch_valid), 32'd0);
        chk("t6_ack_cleared", 32'(wr_ack), 32'd0);
        chk("t6_lowest_first", 32'(rf_read_addr), 32'd1);
        tick();
        at_mid();
        chk("t6_first_resp", 32'(fetch_valid), 32'h2);
        chk("t6_first_data", 32'(fetch_data), 32'h1001);
        tick();
        fetch_req = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
